// File: rtl/breath_pkg.sv
// Shared definitions for the breathing-LED sequencer: FSM encoding and
// the layout of a pattern-table entry {hold[6:3], rgb[2:0]}.
package breath_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_HOLD      = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_ADVANCE   = 3'd5;

  localparam int CFG_W    = 7;
  localparam int HOLD_MSB = 6;
  localparam int HOLD_LSB = 3;
  localparam int RGB_MSB  = 2;
  localparam int RGB_LSB  = 0;

  function automatic logic [3:0] cfg_hold(input logic [CFG_W-1:0] entry);
    return entry[HOLD_MSB:HOLD_LSB];
  endfunction

  function automatic logic [2:0] cfg_rgb(input logic [CFG_W-1:0] entry);
    return entry[RGB_MSB:RGB_LSB];
  endfunction

endpackage

// File: rtl/breath_pwm.sv
// Free-running PWM counter and comparator gating the active colour.
// Inputs are the sequencer's next-cycle values so rgb_o lines up with level_o.
module breath_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [PWM_BITS-1:0] level_i,
  input  logic [2:0]          rgb_i,
  output logic [2:0]          rgb_o
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] w_cnt_nxt;
  logic [2:0]          r_rgb_o;

  assign w_cnt_nxt = r_cnt + PWM_BITS'(1);

  // counter advance and registered compare against the post-edge count
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_cnt   <= {PWM_BITS{1'b0}};
      r_rgb_o <= 3'b000;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_rgb_o <= rgb_i & {3{w_cnt_nxt < level_i}};
    end
  end

  assign rgb_o = r_rgb_o;

endmodule

// File: rtl/breath_sequencer.sv
// Breathing-LED pattern sequencer: walks a small table of {hold, rgb} entries,
// ramping brightness up, holding, and ramping down for each entry.
module breath_sequencer
  import breath_pkg::*;
#(
  parameter int STEP_TICKS = 61035,
  parameter int PWM_BITS   = 8,
  parameter int NUM_STEPS  = 8,
  localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
  input  logic                clk_div_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                loop_i,
  input  logic                cfg_we_i,
  input  logic [STEP_W-1:0]   cfg_addr_i,
  input  logic [CFG_W-1:0]    cfg_data_i,
  output logic [2:0]          rgb_o,
  output logic [PWM_BITS-1:0] level_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int PRE_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] LVL_MAX  = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] LVL_ZERO = {PWM_BITS{1'b0}};

  logic [CFG_W-1:0]    r_table [NUM_STEPS];
  logic [2:0]          r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic [PWM_BITS-1:0] r_level, w_level_nxt, w_lvl_inc, w_lvl_dec;
  logic [2:0]          r_rgb, w_rgb_nxt;
  logic [3:0]          r_hold, w_hold_nxt, r_hold_left, w_hold_left_nxt;
  logic [PRE_W-1:0]    r_presc;
  logic                w_tick, w_done_nxt;
  logic                r_busy, r_done;

  assign w_tick    = (r_presc == PRE_W'(STEP_TICKS - 1));
  assign w_lvl_inc = (r_level == LVL_MAX)  ? LVL_MAX  : r_level + PWM_BITS'(1);
  assign w_lvl_dec = (r_level == LVL_ZERO) ? LVL_ZERO : r_level - PWM_BITS'(1);

  // next-state, level and active-entry decode; stop overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    w_step_nxt      = r_step;
    w_level_nxt     = r_level;
    w_rgb_nxt       = r_rgb;
    w_hold_nxt      = r_hold;
    w_hold_left_nxt = r_hold_left;
    w_done_nxt      = 1'b0;
    if (stop_i && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_level_nxt = LVL_ZERO;
      w_done_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            w_state_nxt = ST_LOAD;
            w_step_nxt  = {STEP_W{1'b0}};
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LOAD: begin
          w_rgb_nxt  = cfg_rgb(r_table[r_step]);
          w_hold_nxt = cfg_hold(r_table[r_step]);
          if (cfg_rgb(r_table[r_step]) == 3'b000) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          if (w_tick) begin
            w_level_nxt     = w_lvl_inc;
            w_hold_left_nxt = r_hold;
            if (w_lvl_inc == LVL_MAX) begin
              w_state_nxt = (r_hold == 4'd0) ? ST_RAMP_DOWN : ST_HOLD;
            end else begin
              w_state_nxt = ST_RAMP_UP;
            end
          end else begin
            w_state_nxt = ST_RAMP_UP;
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            w_hold_left_nxt = r_hold_left - 4'd1;
            w_state_nxt     = (r_hold_left == 4'd1) ? ST_RAMP_DOWN : ST_HOLD;
          end else begin
            w_state_nxt = ST_HOLD;
          end
        end
        ST_RAMP_DOWN: begin
          if (w_tick) begin
            w_level_nxt = w_lvl_dec;
            w_state_nxt = (w_lvl_dec == LVL_ZERO) ? ST_ADVANCE : ST_RAMP_DOWN;
          end else begin
            w_state_nxt = ST_RAMP_DOWN;
          end
        end
        ST_ADVANCE: begin
          if (r_step == STEP_W'(NUM_STEPS - 1)) begin
            if (loop_i) begin
              w_step_nxt  = {STEP_W{1'b0}};
              w_state_nxt = ST_LOAD;
            end else begin
              w_state_nxt = ST_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_step_nxt  = r_step + STEP_W'(1);
            w_state_nxt = ST_LOAD;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_level_nxt = LVL_ZERO;
        end
      endcase
    end
  end

  // sequencer state registers
  always_ff @(posedge clk_div_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_step      <= {STEP_W{1'b0}};
      r_level     <= LVL_ZERO;
      r_rgb       <= 3'b000;
      r_hold      <= 4'd0;
      r_hold_left <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_step      <= w_step_nxt;
      r_level     <= w_level_nxt;
      r_rgb       <= w_rgb_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_left <= w_hold_left_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= w_done_nxt;
    end
  end

  // tick prescaler, restarted on every state entry and parked in IDLE
  always_ff @(posedge clk_div_i) begin
    if (!rst_n_i) begin
      r_presc <= {PRE_W{1'b0}};
    end else if ((r_state == ST_IDLE) || (w_state_nxt != r_state) || w_tick) begin
      r_presc <= {PRE_W{1'b0}};
    end else begin
      r_presc <= r_presc + PRE_W'(1);
    end
  end

  // pattern table; the active entry only picks up edits at its next LOAD
  always_ff @(posedge clk_div_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_table[i] <= {CFG_W{1'b0}};
      end
    end else if (cfg_we_i) begin
      r_table[cfg_addr_i] <= cfg_data_i;
    end else begin
      r_table[cfg_addr_i] <= r_table[cfg_addr_i];
    end
  end

  breath_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk_i   (clk_div_i),
    .rst_n_i (rst_n_i),
    .level_i (w_level_nxt),
    .rgb_i   (w_rgb_nxt),
    .rgb_o   (rgb_o)
  );

  assign level_o = r_level;
  assign step_o  = r_step;
  assign busy_o  = r_busy;
  assign done_o  = r_done;

endmodule

// File: tb/tb_breath_sequencer.sv
// Directed self-checking bench for breath_sequencer with
// STEP_TICKS=4, PWM_BITS=3, NUM_STEPS=4.
module tb_breath_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, loop_en, we;
  logic [1:0] addr;
  logic [6:0] data;
  logic [2:0] rgb;
  logic [2:0] level;
  logic [1:0] step;
  logic       busy, done;
  logic [2:0] pc;
  logic [2:0] ref_level;
  logic [2:0] ref_rgb;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  breath_sequencer #(
    .STEP_TICKS (4),
    .PWM_BITS   (3),
    .NUM_STEPS  (4)
  ) dut (
    .clk_div_i  (clk),
    .rst_n_i    (rst_n),
    .start_i    (start),
    .stop_i     (stop),
    .loop_i     (loop_en),
    .cfg_we_i   (we),
    .cfg_addr_i (addr),
    .cfg_data_i (data),
    .rgb_o      (rgb),
    .level_o    (level),
    .step_o     (step),
    .busy_o     (busy),
    .done_o     (done)
  );

  breath_pwm #(
    .PWM_BITS (3)
  ) u_pwm_ref (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .level_i (ref_level),
    .rgb_i   (3'b111),
    .rgb_o   (ref_rgb)
  );

  // reference PWM phase: zero in reset, +1 per edge otherwise
  always @(posedge clk) begin
    if (!rst_n) pc <= 3'd0;
    else        pc <= pc + 3'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [6:0] d);
    we = 1'b1; addr = a; data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_lvl, cyc, cnt, changes;
    int exp_steps[4];
    logic [1:0] prev;
    logic bad, seen;
    exp_steps = '{1, 2, 3, 0};
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    we = 1'b0; addr = 2'd0; data = 7'd0; ref_level = 3'd4;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_step",  32'(step),  32'd0);
    chk("rst_rgb",   32'(rgb),   32'd0);
    rst_n = 1'b1;

    // stop while idle does nothing
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("idle_stop_done", 32'(done), 32'd0);
    chk("idle_stop_busy", 32'(busy), 32'd0);

    // single entry, hold 2: full breath profile, start mid-ramp ignored
    wr(2'd0, 7'b0010101);
    wr(2'd1, 7'b0000000);
    pulse_start();
    chk("load_busy", 32'(busy), 32'd1);
    @(negedge clk);
    for (int n = 0; n < 68; n++) begin
      if (n < 28)       exp_lvl = n / 4;
      else if (n < 36)  exp_lvl = 7;
      else if (n <= 64) exp_lvl = 7 - (n - 36) / 4;
      else              exp_lvl = 0;
      chk("prof_level", 32'(level), 32'(exp_lvl));
      chk("prof_busy",  32'(busy),  (n <= 65) ? 32'd1 : 32'd0);
      chk("prof_done",  32'(done),  (n == 66) ? 32'd1 : 32'd0);
      chk("prof_rgb",   32'(rgb),   (int'(pc) < exp_lvl) ? 32'd5 : 32'd0);
      if (n <= 64) chk("prof_step", 32'(step), 32'd0);
      if (n == 65) chk("prof_step", 32'(step), 32'd1);
      start = (n == 10);
      @(negedge clk);
    end

    // four hold-0 entries with looping, then drop loop
    for (int k = 0; k < 4; k++) wr(2'(k), 7'(k + 1));
    loop_en = 1'b1;
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      cyc = 0; cnt = 0; prev = step;
      while (step == prev && cyc < 200) begin
        if (level == 3'd7) cnt++;
        @(negedge clk); cyc++;
      end
      chk("loop_step", 32'(step), 32'(exp_steps[k]));
      chk("loop_top_dwell", 32'(cnt), 32'd4);
    end
    loop_en = 1'b0;
    cyc = 0; changes = 0; prev = step;
    while (!done && cyc < 400) begin
      if (step != prev) changes++;
      prev = step;
      @(negedge clk); cyc++;
    end
    chk("noloop_done", 32'(done), 32'd1);
    chk("noloop_busy", 32'(busy), 32'd0);
    chk("noloop_step", 32'(step), 32'd3);
    chk("noloop_changes", 32'(changes), 32'd3);

    // stop and start together mid ramp-up
    pulse_start();
    repeat (10) @(negedge clk);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    chk("abort_pre_lvl",  32'(level != 3'd0), 32'd1);
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_level", 32'(level), 32'd0);
    chk("abort_rgb",   32'(rgb),   32'd0);
    chk("abort_done",  32'(done),  32'd1);
    cnt = 0;
    repeat (5) begin @(negedge clk); if (done) cnt++; end
    chk("abort_single_done", 32'(cnt), 32'd0);
    chk("abort_post_busy",   32'(busy), 32'd0);

    // rewrite entry 0 while it is active
    wr(2'd0, 7'b0000001);
    loop_en = 1'b1;
    pulse_start();
    repeat (8) @(negedge clk);
    wr(2'd0, 7'b0000110);
    bad = 1'b0; seen = 1'b0; cyc = 0;
    while (step == 2'd0 && cyc < 200) begin
      if ((rgb & 3'b110) != 3'b000) bad = 1'b1;
      if (rgb == 3'b001) seen = 1'b1;
      @(negedge clk); cyc++;
    end
    chk("rewr_old_kept", 32'(bad),  32'd0);
    chk("rewr_old_seen", 32'(seen), 32'd1);
    cyc = 0;
    while (step != 2'd0 && cyc < 400) begin @(negedge clk); cyc++; end
    bad = 1'b0; seen = 1'b0; cyc = 0;
    while (step == 2'd0 && cyc < 200) begin
      if ((rgb & 3'b001) != 3'b000) bad = 1'b1;
      if (rgb == 3'b110) seen = 1'b1;
      @(negedge clk); cyc++;
    end
    chk("rewr_new_only", 32'(bad),  32'd0);
    chk("rewr_new_seen", 32'(seen), 32'd1);
    stop = 1'b1; @(negedge clk); stop = 1'b0;
    chk("rewr_stop_done", 32'(done), 32'd1);

    // standalone PWM duty: level 4 then level 0
    cnt = 0;
    repeat (16) begin @(negedge clk); if (ref_rgb == 3'b111) cnt++; end
    chk("pwm_duty4", 32'(cnt), 32'd8);
    ref_level = 3'd0;
    @(negedge clk);
    cnt = 0;
    repeat (16) begin @(negedge clk); if (ref_rgb != 3'b000) cnt++; end
    chk("pwm_duty0", 32'(cnt), 32'd0);

    // reset during HOLD clears everything including the table
    loop_en = 1'b0;
    wr(2'd0, 7'b0010101);
    pulse_start();
    cyc = 0;
    while (level != 3'd7 && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    chk("hold_level", 32'(level), 32'd7);
    chk("hold_busy",  32'(busy),  32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_busy",  32'(busy),  32'd0);
    chk("mrst_done",  32'(done),  32'd0);
    chk("mrst_level", 32'(level), 32'd0);
    chk("mrst_step",  32'(step),  32'd0);
    chk("mrst_rgb",   32'(rgb),   32'd0);
    @(negedge clk);
    chk("mrst_no_done", 32'(done), 32'd0);
    pulse_start();
    chk("tbl_load_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("tbl_zero_done", 32'(done), 32'd1);
    chk("tbl_zero_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
